// File: rtl/native_bram_pipe_pkg.sv
// Shared sizing helpers and state encoding for the native BRAM pipeline.
package native_bram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  function automatic int unsigned line_count(input int unsigned addr_width,
                                             input int unsigned data_width);
    return ((32'd1 << addr_width) * 8) / data_width;
  endfunction

  function automatic int unsigned line_offset(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic bit latency_legal(input int unsigned latency);
    return (latency == 1) || (latency == 2);
  endfunction

endpackage

// File: rtl/native_bram_pipe_resp_fifo.sv
// Response FIFO with first-word fall-through: an empty FIFO passes input
// straight to the output in the same cycle, so it adds no read latency.
module native_bram_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : slots[rd_ptr];
  assign bypass    = empty && in_valid && out_ready;
  assign push      = in_valid && in_ready && !bypass;
  assign pop       = !empty && out_ready;

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/native_bram_pipe.sv
// Byte-enabled single-port BRAM with valid/ready request and response sides,
// 1- or 2-cycle read pipeline, credit-bounded response buffer and zero-fill.
module native_bram_pipe
  import native_bram_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_ADDR_WIDTH = 11,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned CLEAR_ON_RESET  = 0,
  parameter string       INIT_FILE       = "initrom.mem"
) (
  input  logic                        clka,
  input  logic                        rsta_n,
  input  logic                        ena,
  output logic                        rdya,
  input  logic [BRAM_ADDR_WIDTH-1:0]  addra,
  input  logic [MEM_DATA_WIDTH/8-1:0] wea,
  input  logic [MEM_DATA_WIDTH-1:0]   dina,
  output logic [MEM_DATA_WIDTH-1:0]   douta,
  output logic                        dvalida,
  input  logic                        drdya,
  output logic                        init_done
);

  localparam int unsigned BYTES = MEM_DATA_WIDTH / 8;
  localparam int unsigned LINES = line_count(BRAM_ADDR_WIDTH, MEM_DATA_WIDTH);
  localparam int unsigned OFF   = line_offset(MEM_DATA_WIDTH);
  localparam int unsigned LW    = BRAM_ADDR_WIDTH - OFF;
  localparam int unsigned DEPTH = READ_LATENCY + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("native_bram_pipe: READ_LATENCY must be 1 or 2");
  end

  logic [MEM_DATA_WIDTH-1:0] mem [LINES];

  if (OFF > 0) begin : g_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^addra[OFF-1:0];
  end

  state_t                    state;
  logic [LW-1:0]             clr_idx;
  logic [LW-1:0]             line;
  logic [CW-1:0]             credits;
  logic                      accept;
  logic                      rd_acc;
  logic                      wr_acc;
  logic                      clearing;
  logic                      pop;
  logic                      rd_valid;
  logic [MEM_DATA_WIDTH-1:0] rd_data;
  logic                      pipe_valid;
  logic [MEM_DATA_WIDTH-1:0] pipe_data;
  logic                      fifo_in_ready;
  logic                      fifo_valid;
  logic [MEM_DATA_WIDTH-1:0] fifo_data;

  assign line     = addra[BRAM_ADDR_WIDTH-1:OFF];
  assign rdya     = rsta_n && (state == RUN) && (credits < CW'(DEPTH)) && fifo_in_ready;
  assign accept   = ena && rdya;
  assign rd_acc   = accept && (wea == '0);
  assign wr_acc   = accept && (wea != '0);
  assign clearing = rsta_n && (state == CLEAR) && (CLEAR_ON_RESET != 0);

  // Zero-fill shares the single write port; it never overlaps requests.
  always_ff @(posedge clka) begin
    if (clearing) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < BYTES; i++)
        if (wea[i]) mem[line][i*8 +: 8] <= dina[i*8 +: 8];
    end
    if (rd_acc) rd_data <= mem[line];
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) rd_valid <= 1'b0;
    else         rd_valid <= rd_acc;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                      out_valid_q;
    logic [MEM_DATA_WIDTH-1:0] out_data_q;
    always_ff @(posedge clka) begin
      out_data_q <= rd_data;
      if (!rsta_n) out_valid_q <= 1'b0;
      else         out_valid_q <= rd_valid;
    end
    assign pipe_valid = out_valid_q;
    assign pipe_data  = out_data_q;
  end else begin : g_lat1
    assign pipe_valid = rd_valid;
    assign pipe_data  = rd_data;
  end

  // Credits cover the pipeline plus the buffer, so the buffer never overflows.
  native_bram_resp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(MEM_DATA_WIDTH)
  ) u_resp_fifo (
    .clk      (clka),
    .rst_n    (rsta_n),
    .in_valid (pipe_valid),
    .in_ready (fifo_in_ready),
    .in_data  (pipe_data),
    .out_valid(fifo_valid),
    .out_ready(drdya),
    .out_data (fifo_data)
  );

  assign dvalida = fifo_valid;
  assign douta   = fifo_valid ? fifo_data : '0;
  assign pop     = fifo_valid && drdya;

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
      credits   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (CLEAR_ON_RESET == 0 || clr_idx == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        RUN: ;
      endcase
      case ({rd_acc, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_native_bram_pipe.sv
// Scoreboard bench: dut0 has READ_LATENCY=2 with zero-fill, dut1 has
// READ_LATENCY=1 without; a negedge monitor pops expected responses.
module tb_native_bram_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic        ena      [2];
  logic        rdya     [2];
  logic [10:0] addra    [2];
  logic [3:0]  wea      [2];
  logic [31:0] dina     [2];
  logic [31:0] douta    [2];
  logic        dvalida  [2];
  logic        drdya    [2];
  logic        init_done[2];

  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] model[16];
  logic        stalled[2] = '{1'b0, 1'b0};
  logic [31:0] held[2];

  native_bram_pipe #(
    .MEM_DATA_WIDTH(32), .BRAM_ADDR_WIDTH(11), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) u_dut0 (
    .clka(clk), .rsta_n(rst_n[0]), .ena(ena[0]), .rdya(rdya[0]),
    .addra(addra[0]), .wea(wea[0]), .dina(dina[0]), .douta(douta[0]),
    .dvalida(dvalida[0]), .drdya(drdya[0]), .init_done(init_done[0])
  );

  native_bram_pipe #(
    .MEM_DATA_WIDTH(32), .BRAM_ADDR_WIDTH(11), .READ_LATENCY(1),
    .CLEAR_ON_RESET(0), .INIT_FILE("")
  ) u_dut1 (
    .clka(clk), .rsta_n(rst_n[1]), .ena(ena[1]), .rdya(rdya[1]),
    .addra(addra[1]), .wea(wea[1]), .dina(dina[1]), .douta(douta[1]),
    .dvalida(dvalida[1]), .drdya(drdya[1]), .init_done(init_done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int d, input logic [31:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] pop_exp(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (stalled[d]) begin
          check($sformatf("stall_valid%0d", d), 32'(dvalida[d]), 32'd1);
          check($sformatf("stall_hold%0d", d), douta[d], held[d]);
        end
        if (dvalida[d] && drdya[d]) begin
          if (q_size(d) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp%0d: got 0x%08h with no response outstanding", d, douta[d]);
          end else begin
            check($sformatf("resp%0d", d), douta[d], pop_exp(d));
          end
        end
        stalled[d] = dvalida[d] && !drdya[d];
        held[d]    = douta[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int d, input logic [10:0] a, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] exp);
    bit done = 1'b0;
    ena[d] = 1'b1; addra[d] = a; wea[d] = be; dina[d] = data;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (rdya[d]) begin
        done = 1'b1;
        if (be == 4'h0) push_exp(d, exp);
      end
      @(posedge clk);
      #1;
    end
    ena[d] = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL req_timeout%0d: rdya stayed 0, required 1", d);
    end
  endtask

  task automatic wait_drain(input int d);
    for (int n = 0; n < 64 && q_size(d) != 0; n++) @(negedge clk);
    check($sformatf("drain%0d", d), 32'(q_size(d)), 32'd0);
  endtask

  initial begin
    int          cnt[2];
    int          rcnt;
    int          idx;
    bit          have;
    logic [3:0]  ln;
    logic [3:0]  be;
    logic [31:0] dat;
    logic [31:0] r;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; ena[d] = 1'b0; addra[d] = '0;
      wea[d] = '0; dina[d] = '0; drdya[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rdya%0d", d), 32'(rdya[d]), 32'd0);
      check($sformatf("rst_dvalid%0d", d), 32'(dvalida[d]), 32'd0);
      check($sformatf("rst_douta%0d", d), douta[d], 32'd0);
      check($sformatf("rst_init_done%0d", d), 32'(init_done[d]), 32'd0);
    end
    mon_en = 1'b1;
    step();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    cnt[0] = 0; cnt[1] = 0; rcnt = 0;
    for (int n = 0; n < 2000 && !(init_done[0] && init_done[1]); n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (!init_done[d]) cnt[d]++;
      if (!rdya[0]) rcnt++;
    end
    check("clear_cycles", 32'(cnt[0]), 32'd512);
    check("noclear_cycles", 32'(cnt[1]), 32'd1);
    check("clear_rdya_low", 32'(rcnt), 32'd512);
    check("rdya_after_clear", 32'(rdya[0]), 32'd1);
    check("rdya_noclear", 32'(rdya[1]), 32'd1);
    step();

    // dut1: latency 1, then a 512-read stream with no bubbles.
    do_req(1, 11'h040, 4'hF, 32'h12345678, 32'h0);
    do_req(1, 11'h040, 4'h0, 32'h0, 32'h12345678);
    @(negedge clk);
    check("rl1_latency", 32'(dvalida[1]), 32'd1);
    step();
    for (int k = 0; k < 512; k++) begin
      dat = k * 32'h01010101;
      do_req(1, 11'(k * 4), 4'hF, dat, 32'h0);
    end
    for (int k = 0; k < 512; k++) begin
      ena[1] = 1'b1; addra[1] = 11'(k * 4); wea[1] = 4'h0;
      @(negedge clk);
      check("tput_rdya", 32'(rdya[1]), 32'd1);
      push_exp(1, k * 32'h01010101);
      step();
    end
    ena[1] = 1'b0;
    wait_drain(1);
    step();

    // dut0: latency 2, then a reset pulse mid-sweep restarts the zero-fill.
    do_req(0, 11'h000, 4'hF, 32'hDEADBEEF, 32'h0);
    do_req(0, 11'h7FC, 4'hF, 32'hCAFEF00D, 32'h0);
    do_req(0, 11'h000, 4'h0, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    check("rl2_not_early", 32'(dvalida[0]), 32'd0);
    @(negedge clk);
    check("rl2_latency", 32'(dvalida[0]), 32'd1);
    step();
    do_req(0, 11'h7FC, 4'h0, 32'h0, 32'hCAFEF00D);
    wait_drain(0);
    step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    repeat (199) step();
    @(negedge clk);
    check("mid_clear_busy", 32'(init_done[0]), 32'd0);
    step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    cnt[0] = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (init_done[0]) break;
      cnt[0]++;
    end
    check("reclear_cycles", 32'(cnt[0]), 32'd512);
    step();
    do_req(0, 11'h000, 4'h0, 32'h0, 32'h00000000);
    do_req(0, 11'h7FC, 4'h0, 32'h0, 32'h00000000);

    do_req(0, 11'h010, 4'hF, 32'hAABBCCDD, 32'h0);
    do_req(0, 11'h010, 4'b0101, 32'h11223344, 32'h0);
    do_req(0, 11'h010, 4'h0, 32'h0, 32'hAA22CC44);
    do_req(0, 11'h013, 4'h0, 32'h0, 32'hAA22CC44);
    wait_drain(0);
    step();

    // Backpressure: only READ_LATENCY+1 reads may be outstanding.
    for (int i = 0; i < 5; i++) do_req(0, 11'(32'h020 + i * 4), 4'hF, 32'h50000000 + i, 32'h0);
    drdya[0] = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      ena[0] = (idx < 5); addra[0] = 11'(32'h020 + idx * 4); wea[0] = 4'h0;
      @(negedge clk);
      if (ena[0] && rdya[0]) begin
        push_exp(0, 32'h50000000 + idx);
        idx++;
      end
      step();
    end
    ena[0] = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(idx), 32'd3);
    check("bp_rdya_low", 32'(rdya[0]), 32'd0);
    check("bp_dvalid", 32'(dvalida[0]), 32'd1);
    step();
    drdya[0] = 1'b1;
    wait_drain(0);
    check("bp_rdya_back", 32'(rdya[0]), 32'd1);
    step();

    // Mixed traffic against a reference model with drdya toggling.
    for (int i = 0; i < 16; i++) begin
      model[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
      do_req(0, 11'(32'h100 + i * 4), 4'hF, model[i], 32'h0);
    end
    have = 1'b0; ln = '0; be = '0;
    for (int c = 0; c < 400; c++) begin
      drdya[0] = ~drdya[0];
      if (!have) begin
        r  = $urandom;
        ln = r[3:0];
        be = r[6] ? ((r[10:7] == 4'h0) ? 4'h1 : r[10:7]) : 4'h0;
        ena[0] = 1'b1; addra[0] = 11'(32'h100 + ln * 4 + r[5:4]);
        wea[0] = be; dina[0] = $urandom;
        have = 1'b1;
      end
      @(negedge clk);
      if (rdya[0]) begin
        if (be == 4'h0) begin
          push_exp(0, model[ln]);
        end else begin
          for (int i = 0; i < 4; i++)
            if (be[i]) model[ln][i*8 +: 8] = dina[0][i*8 +: 8];
        end
        have = 1'b0;
      end
      step();
    end
    ena[0] = 1'b0;
    drdya[0] = 1'b1;
    wait_drain(0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
